uart_rx_ctrl: RTL
=================

// Module: uart_rx_ctrl
// PURPOSE
//  Controller/buffer for the uart_rx receiver: generates its over-8 clock enable, captures each received
//  byte on the recv flag's rising edge, and queues good bytes in a FIFO for the bus. Keeps sticky
//  overrun/framing status and a level interrupt. Sits between uart_rx and the peripheral bus register file.
// PARAMETERS
//  BUS_CLK        10_000_000  bus clock frequency, Hz
//  BAUD           9600        baud rate; DIV = round(BUS_CLK/(BAUD*8)), must be >= 2
//  FIFO_DEPTH     8           RX FIFO entries, power of 2, >= 2
//  IRQ_LEVEL      1           irq asserted when count >= IRQ_LEVEL (1..FIFO_DEPTH)
//  TIMEOUT_CHARS  4           idle char-times before timeout (UART_RX_TIMEOUT_EN only)
// PORTS
//  clk        in   1   bus clock; the only clock
//  rst        in   1   reset, asynchronous, active-high
//  enable     in   1   receiver enable
//  baud_en    out  1   one-clk pulse every DIV clks -> uart_rx.clk_en
//  rx_din     in   8   uart_rx.din
//  rx_busy    in   1   uart_rx.busy
//  rx_recv    in   1   uart_rx.recv (high for one baud_en period)
//  rx_err     in   1   uart_rx.err (valid while rx_recv high)
//  rd_en      in   1   pop head entry
//  rd_data    out  8   head entry; 0 when empty
//  empty      out  1   FIFO empty
//  full       out  1   FIFO full
//  count      out  $clog2(FIFO_DEPTH+1)  entries held
//  overrun    out  1   sticky: byte dropped because FIFO full
//  frame_err  out  1   sticky: byte received with bad stop bit
//  timeout    out  1   sticky idle timeout (0 without UART_RX_TIMEOUT_EN)
//  clr_err    in   1   clears overrun, frame_err, timeout
//  irq        out  1   (count>=IRQ_LEVEL) | overrun | frame_err | timeout
// BEHAVIOUR
//  Reset (async, rst=1): state OFF; baud counter 0; baud_en 0; FIFO empty (count 0, empty 1, full 0,
//   rd_data 0); overrun/frame_err/timeout 0; irq 0; recv edge-detect reg 0. FIFO storage is not reset.
//   Reset mid-byte abandons it; pushes resume only after next recv rising edge.
//  Baud gen: counter 0..DIV-1 runs in IDLE/RXING/STOPPING; baud_en=1 for the clk where counter==DIV-1,
//   then counter wraps to 0. In OFF, counter held 0, baud_en 0.
//  FSM: OFF -enable-> IDLE; IDLE -rx_busy-> RXING; RXING -!rx_busy-> IDLE;
//   IDLE & !enable -> OFF; RXING & !enable -> STOPPING (baud_en keeps running, byte completes);
//   STOPPING -!rx_busy-> OFF (enable re-asserted in STOPPING -> RXING).
//  Capture: push event = rx_recv & !recv_q (recv_q = rx_recv delayed 1 clk); exactly one per byte.
//   rx_err=1 -> set frame_err, byte discarded. Else full & !rd_en -> set overrun, byte discarded, FIFO
//   unchanged. Else rx_din written at tail; count+1 next clk (visible 1 clk after the event).
//  Pop: rd_en & !empty advances head next clk; rd_en when empty ignored, no flag.
//  Push+pop same clk: both take effect, count unchanged (legal when full: no overrun).
//  Pointers $clog2(FIFO_DEPTH) bits, wrap mod FIFO_DEPTH; full = count==FIFO_DEPTH.
//  rd_data = mem[head] combinationally when !empty, else 0.
//  Sticky flags: set has priority over clr_err in the same clk. irq is combinational from regs.
// CONFIGURATION
//  `UART_RX_TIMEOUT_EN defined: counter of baud_en pulses runs while !empty & !rx_busy; cleared by push,
//   pop, or empty; reaching TIMEOUT_CHARS*80 sets timeout (sticky, counter holds). Cleared by clr_err
//   or any pop.
//  Not defined: no timeout counter; timeout tied 0; irq excludes it.
// TESTING
//  1 BUS_CLK=10M, BAUD=9600: enable=1 -> baud_en period 130 clks (DIV=130), first pulse 130 clks in.
//  2 uart_rx receives 0xA5 good stop -> one push, rd_data=0xA5, count=1, irq=1; rd_en -> empty, irq=0.
//  3 Receive 9 bytes 0x01..0x09 (depth 8), no reads -> count=8, full, overrun=1, rd yields 0x01..0x08.
//  4 Full FIFO, pulse rd_en on same clk as 9th push -> count stays 8, overrun=0, last entry = new byte.
//  5 Byte with stop bit 0 -> frame_err=1, count unchanged; clr_err -> frame_err=0, irq=0.
//  6 enable=0 mid-byte -> STOPPING, byte 0x3C still pushed, then OFF, baud_en stays 0; rst mid-byte ->
//    all outputs at reset values immediately; timeout build: 1 byte then idle 320 baud_en -> timeout=1.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: baud enable, recv-edge capture and RX FIFO with sticky status and irq; `UART_RX_TIMEOUT_EN adds idle timeout
module uart_rx_ctrl #(
  parameter int BUS_CLK       = 10_000_000,
  parameter int BAUD          = 9600,
  parameter int FIFO_DEPTH    = 8,
  parameter int IRQ_LEVEL     = 1,
  parameter int TIMEOUT_CHARS = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enable,
  output logic                              baud_en,
  input  logic [7:0]                        rx_din,
  input  logic                              rx_busy,
  input  logic                              rx_recv,
  input  logic                              rx_err,
  input  logic                              rd_en,
  output logic [7:0]                        rd_data,
  output logic                              empty,
  output logic                              full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
  output logic                              overrun,
  output logic                              frame_err,
  output logic                              timeout,
  input  logic                              clr_err,
  output logic                              irq
);
  localparam int DIV = (BUS_CLK + BAUD * 4) / (BAUD * 8);
  localparam int DW  = $clog2(DIV);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);

  if (DIV < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      IRQ_LEVEL < 1 || IRQ_LEVEL > FIFO_DEPTH || TIMEOUT_CHARS < 1) begin : g_bad_params
    $error("uart_rx_ctrl: illegal parameter set");
  end

  typedef enum logic [1:0] {OFF, IDLE, RXING, STOPPING} state_t;
  state_t state, state_n;
  logic [DW-1:0] bcnt;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] head, tail;
  logic recv_q, push_ev, do_pop, wr, ovr_set, frm_set;

  assign baud_en = state != OFF && bcnt == DW'(DIV - 1);
  assign push_ev = rx_recv & ~recv_q;
  assign do_pop  = rd_en & ~empty;
  assign frm_set = push_ev & rx_err;
  assign ovr_set = push_ev & ~rx_err & full & ~rd_en;
  assign wr      = push_ev & ~rx_err & (~full | rd_en);
  assign empty   = count == '0;
  assign full    = count == CW'(FIFO_DEPTH);
  assign rd_data = empty ? 8'h00 : mem[head];
  assign irq     = count >= CW'(IRQ_LEVEL) | overrun | frame_err | timeout;

  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= OFF;
    else state <= state_n;

  // enable/busy driven sequencing; a byte in flight completes after enable drops
  always_comb begin
    state_n = state;
    case (state)
      OFF:      state_n = enable ? IDLE : OFF;
      IDLE:     state_n = !enable ? OFF : rx_busy ? RXING : IDLE;
      RXING:    state_n = !rx_busy ? IDLE : !enable ? STOPPING : RXING;
      STOPPING: state_n = enable ? RXING : !rx_busy ? OFF : STOPPING;
      default:  state_n = OFF;
    endcase
  end

  // over-8 baud divider, parked at 0 while off
  always_ff @(posedge clk or posedge rst)
    if (rst) bcnt <= '0;
    else bcnt <= (state == OFF || baud_en) ? '0 : bcnt + DW'(1);

  // recv rising-edge detect, pointers and occupancy
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      recv_q <= 1'b0;
      head   <= '0;
      tail   <= '0;
      count  <= '0;
    end else begin
      recv_q <= rx_recv;
      head   <= do_pop ? head + AW'(1) : head;
      tail   <= wr ? tail + AW'(1) : tail;
      count  <= (wr & ~do_pop) ? count + CW'(1) : (~wr & do_pop) ? count - CW'(1) : count;
    end

  // FIFO storage, intentionally not reset
  always_ff @(posedge clk)
    if (wr) mem[tail] <= rx_din;

  // sticky error flags; a set wins over a same-cycle clear
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= ovr_set | (overrun & ~clr_err);
      frame_err <= frm_set | (frame_err & ~clr_err);
    end

`ifdef UART_RX_TIMEOUT_EN
  localparam int TO_MAX = TIMEOUT_CHARS * 80;
  localparam int TW     = $clog2(TO_MAX + 1);
  logic [TW-1:0] tcnt;
  logic t_clr, t_inc, t_set;
  assign t_clr = wr | do_pop | empty;
  assign t_inc = baud_en & ~rx_busy & (tcnt != TW'(TO_MAX));
  assign t_set = ~t_clr & t_inc & (tcnt == TW'(TO_MAX - 1));

  // idle char-time counter, saturates at the limit
  always_ff @(posedge clk or posedge rst)
    if (rst) tcnt <= '0;
    else tcnt <= t_clr ? '0 : t_inc ? tcnt + TW'(1) : tcnt;

  // sticky timeout, cleared by clr_err or any pop
  always_ff @(posedge clk or posedge rst)
    if (rst) timeout <= 1'b0;
    else timeout <= t_set | (timeout & ~clr_err & ~do_pop);
`else
  assign timeout = 1'b0;
`endif
endmodule
